// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Purpose:
//   Turns a raw, asynchronous input (pushbutton, switch contact) into a clean,
//   glitch-free level. The input first passes through a SYNC_STAGES-deep flop
//   chain. A four-state FSM then accepts a change of level only after the
//   synchronized value has held for STABLE_CYCLES consecutive clocks. a_clean
//   feeds the data input of the downstream edge detector.
//
// Optional feature:
//   Define DEBOUNCE_GLITCH_CNT_EN to add a saturating counter of rejected
//   transitions. This adds the glitch_clr / glitch_count ports. Without the
//   macro those ports and the counter do not exist. a_clean and busy behave
//   identically in both builds.
//
// Parameters:
//   SYNC_STAGES    synchronizer depth (>= 2)
//   STABLE_CYCLES  consecutive stable synchronized samples needed (>= 2)
//   GLITCH_W       width of glitch_count
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   a_async       in   raw, unsynchronized input
//   a_clean       out  debounced level (registered)
//   busy          out  1 while a candidate change is being qualified (registered)
//   glitch_clr    in   synchronous clear of glitch_count (optional)
//   glitch_count  out  saturating count of rejected transitions (optional)
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_async,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_count,
`endif
  output logic                a_clean,
  output logic                busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_chk_stable
    $error("debounce_sync: STABLE_CYCLES must be >= 2");
  end
  if (GLITCH_W < 1) begin : g_chk_glitch_w
    $error("debounce_sync: GLITCH_W must be >= 1");
  end

  // The counter must hold values up to STABLE_CYCLES-1. In practice it never
  // goes past that value, so it cannot wrap.
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: shift chain. Only its last stage is visible to the FSM.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], a_async};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------------------
  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           a_clean_reg, a_clean_next;
  logic           busy_reg, busy_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= LOW;
      cnt_reg     <= CNT_ZERO;
      a_clean_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      a_clean_reg <= a_clean_next;
      busy_reg    <= busy_next;
    end
  end

  // The FSM accepts a change when it sees the first differing sample in
  // LOW/HIGH. That sample loads cnt = 1. The change succeeds on the sample
  // that finds cnt == STABLE_CYCLES-1, which is STABLE_CYCLES consecutive
  // samples in total.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      LOW: begin
        if (s) begin
          state_next = RISE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end

      RISE_WAIT: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      HIGH: begin
        if (!s) begin
          state_next = FALL_WAIT;
          cnt_next   = CNT_ONE;
        end
      end

      FALL_WAIT: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = LOW;
        cnt_next   = CNT_ZERO;
      end
    endcase

    // The outputs are derived from the next state so that they are
    // registered in step with state_reg.
    a_clean_next = (state_next == HIGH) || (state_next == FALL_WAIT);
    busy_next    = (state_next == RISE_WAIT) || (state_next == FALL_WAIT);
  end

  assign a_clean = a_clean_reg;
  assign busy    = busy_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // ---------------------------------------------------------------------------
  // Glitch counter: counts qualification windows that were aborted.
  // ---------------------------------------------------------------------------
  logic                glitch_event;
  logic [GLITCH_W-1:0] glitch_count_reg, glitch_count_next;

  assign glitch_event = ((state_reg == RISE_WAIT) && !s) ||
                        ((state_reg == FALL_WAIT) &&  s);

  // A clear wins over an increment that happens on the same edge.
  // Once the counter reaches all-ones, it holds that value.
  always_comb begin
    glitch_count_next = glitch_count_reg;
    if (glitch_clr) begin
      glitch_count_next = '0;
    end else if (glitch_event && (glitch_count_reg != {GLITCH_W{1'b1}})) begin
      glitch_count_next = glitch_count_reg + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_count_reg <= '0;
    end else begin
      glitch_count_reg <= glitch_count_next;
    end
  end

  assign glitch_count = glitch_count_reg;
`endif

endmodule
